fifo_wr_arbiter: RTL and testbench

- Round-robin write arbiter that shares the single write port of the 64-entry, 32-bit coder FIFO between N_REQ producers, for example parallel symbol/code generators in the Huffman coder.
- Grants one requester at a time for a bounded burst.
- Muxes that requester's data onto the FIFO write port.
- Applies FIFO-full backpressure so the FIFO never sees a write while full.

---
 rtl/fifo_wr_arbiter.sv | 142 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ producers, with bounded bursts and FIFO-full backpressure.
// Optional stall watchdog under `ARB_WATCHDOG_EN`: it frees a grant that stays stalled on a full FIFO.
module fifo_wr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 32,
    parameter int BURST_MAX = 8,
    parameter int WDOG_CYC  = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        last,
    input  logic [N_REQ*DATA_W-1:0] data_in,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        ack,
    input  logic                    fifo_full,
    output logic                    fifo_wr,
    output logic [DATA_W-1:0]       fifo_data,
    output logic                    busy,
    output logic                    wdog_err
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int BW = $clog2(BURST_MAX + 1);

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]    g_q, g_d;
    logic [IW-1:0]    rr_q, rr_d;
    logic [BW-1:0]    beat_q, beat_d;

    logic             found;
    logic [IW-1:0]    pick;
    logic             req_g;
    logic             acc;
    logic             rel;
    logic             wdog_hit;
    logic [IW-1:0]    g_next;

    // First requester at or above rr_q, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req[(int'(rr_q) + i) % N_REQ]) begin
                found = 1'b1;
                pick  = IW'((int'(rr_q) + i) % N_REQ);
            end
        end
    end

    assign busy    = (state_q == BURST);
    assign req_g   = req[g_q];
    assign acc     = busy & req_g & ~fifo_full;
    assign fifo_wr = acc;
    assign ack     = gnt_q & {N_REQ{acc}};
    assign gnt     = gnt_q;
    assign g_next  = (int'(g_q) == N_REQ - 1) ? '0 : g_q + IW'(1);

    always_comb begin
        fifo_data = '0;
        if (busy) fifo_data = data_in[int'(g_q)*DATA_W +: DATA_W];
    end

    // Abandonment (req dropped) frees the port even while the FIFO is full.
    assign rel = (acc & last[g_q])
               | (acc & (beat_q == BW'(BURST_MAX - 1)))
               | ~req_g
               | wdog_hit;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        g_d     = g_q;
        rr_d    = rr_q;
        beat_d  = beat_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = BURST;
                    g_d     = pick;
                    gnt_d   = N_REQ'(1) << pick;
                    beat_d  = '0;
                end
            end
            BURST: begin
                if (acc) beat_d = beat_q + BW'(1);
                if (rel) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    rr_d    = g_next;
                    beat_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            g_q     <= '0;
            rr_q    <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            g_q     <= g_d;
            rr_q    <= rr_d;
            beat_q  <= beat_d;
        end
    end

`ifdef ARB_WATCHDOG_EN
    localparam int SW = (WDOG_CYC > 1) ? $clog2(WDOG_CYC) : 1;

    logic [SW-1:0] stall_q, stall_d;
    logic          wdog_err_q;
    logic          stall;

    assign stall    = busy & req_g & fifo_full;
    assign wdog_hit = stall & (stall_q == SW'(WDOG_CYC - 1));
    assign stall_d  = (stall && !wdog_hit) ? stall_q + SW'(1) : '0;
    assign wdog_err = wdog_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q    <= '0;
            wdog_err_q <= 1'b0;
        end else begin
            stall_q    <= stall_d;
            wdog_err_q <= wdog_hit;
        end
    end
`else
    assign wdog_hit = 1'b0;
    assign wdog_err = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: stimulus pushes expected FIFO words, a monitor pops and compares on each write.
module tb_fifo_wr_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
`ifdef ARB_WATCHDOG_EN
    localparam int WD = 16;
`else
    localparam int WD = 64;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req, last, gnt, ack;
    logic [N*DW-1:0] data_in;
    logic            fifo_full, fifo_wr, busy, wdog_err;
    logic [DW-1:0]   fifo_data;

    int              cnt[N];
    int              lim[N];
    int              exp_cnt[N];
    bit              lastmode[N];
    logic [DW-1:0]   exp_q[$];
    int              n_tests = 0;
    int              n_fail  = 0;

    fifo_wr_arbiter #(.N_REQ(N), .DATA_W(DW), .BURST_MAX(8), .WDOG_CYC(WD)) dut (
        .clk(clk), .rst(rst), .req(req), .last(last), .data_in(data_in),
        .gnt(gnt), .ack(ack), .fifo_full(fifo_full), .fifo_wr(fifo_wr),
        .fifo_data(fifo_data), .busy(busy), .wdog_err(wdog_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input int i, input int c);
        return {4'hA, i[3:0], 8'h5C, c[15:0]};
    endfunction

    // Producers: each offers words cnt..lim-1, advancing on ack.
    always_comb begin
        req     = '0;
        last    = '0;
        data_in = '0;
        for (int i = 0; i < N; i++) begin
            req[i]              = (cnt[i] < lim[i]);
            last[i]             = lastmode[i] && (cnt[i] == lim[i] - 1);
            data_in[i*DW +: DW] = word(i, cnt[i]);
        end
    end

    initial begin
        logic [N-1:0] ack_s;
        forever begin
            @(negedge clk);
            ack_s = ack;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) if (ack_s[i]) cnt[i]++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every FIFO write must match the next expected word.
    initial begin
        forever begin
            @(negedge clk);
            if (fifo_wr) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_wr: got %0h, expected no write at %0t", fifo_data, $time);
                end else begin
                    chk("wr_data", fifo_data, exp_q.pop_front());
                end
                chk("no_wr_when_full", {31'd0, fifo_full}, 32'd0);
            end
        end
    end

    task automatic push(input int i, input int n);
        repeat (n) begin
            exp_q.push_back(word(i, exp_cnt[i]));
            exp_cnt[i]++;
        end
    endtask

    task automatic offer(input int i, input int n, input bit lm);
        lastmode[i] = lm;
        lim[i]      = cnt[i] + n;
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        chk("drain", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic wait_cnt(input int i, input int tgt, input int budget);
        int k = 0;
        while (cnt[i] < tgt && k < budget) begin
            @(posedge clk);
            #2;
            k++;
        end
        chk("wait_cnt", cnt[i], tgt);
    endtask

    task automatic wait_gnt(output logic [N-1:0] g, input int budget);
        int k = 0;
        g = '0;
        while (g == '0 && k < budget) begin
            @(negedge clk);
            g = gnt;
            k++;
        end
    endtask

    task automatic pulse_rst();
        @(posedge clk); #2; rst = 1'b1;
        @(posedge clk); #2; rst = 1'b0;
    endtask

    initial begin
        logic [N-1:0] g, prev_g;
        int s, nw, k, held, werr;
        bit run;
        for (int i = 0; i < N; i++) begin
            cnt[i] = 0; lim[i] = 0; exp_cnt[i] = 0; lastmode[i] = 0;
        end
        fifo_full = 1'b0;
        rst       = 1'b0;
        #1 rst    = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_fifo_wr", fifo_wr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ack", ack, 0);
        chk("rst_wdog", wdog_err, 0);
        @(posedge clk); #2; rst = 1'b0;
        repeat (2) @(posedge clk);
        #2;

        // Single requester, 3 words, last on the third
        offer(2, 3, 1); push(2, 3);
        @(negedge clk); chk("t1_gnt_pre", gnt, 0);
        @(negedge clk); chk("t1_gnt", gnt, 4'b0100); chk("t1_busy", busy, 1);
        for (int j = 0; j < 3; j++) begin
            if (j > 0) @(negedge clk);
            chk("t1_wr", fifo_wr, 1);
        end
        @(negedge clk); chk("t1_bubble_wr", fifo_wr, 0); chk("t1_bubble_gnt", gnt, 0);
        drain(20);

        // Round-robin fairness, all four requesting, no last
        pulse_rst();
        for (int i = 0; i < N; i++) offer(i, 16, 0);
        for (int r = 0; r < 2; r++) for (int i = 0; i < N; i++) push(i, 8);
        @(negedge clk);
        nw = 0; k = 0; prev_g = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (fifo_wr) nw++;
            if (gnt != '0 && prev_g == '0) begin
                if (k < 5) chk("t2_rr_order", gnt, 4'b0001 << (k % 4));
                k++;
            end
            prev_g = gnt;
        end
        chk("t2_writes_in_40", nw, 36);
        drain(100);

        // Backpressure mid-burst of requester 1
        s = cnt[1];
        offer(1, 6, 1); push(1, 6);
        wait_cnt(1, s + 3, 40);
        fifo_full = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("t3_full_wr", fifo_wr, 0);
            chk("t3_full_ack", ack, 0);
            chk("t3_full_gnt", gnt, 4'b0010);
        end
        @(posedge clk); #2; fifo_full = 1'b0;
        @(negedge clk); chk("t3_resume", fifo_wr, 1);
        drain(40);
        chk("t3_words", cnt[1], s + 6);

        // Abandon: requester 3 drops after 2 words, requester 0 next
        offer(3, 2, 0); offer(0, 3, 1);
        push(3, 2); push(0, 3);
        wait_gnt(g, 20); chk("t4_gnt3", g, 4'b1000);
        k = 0;
        while (gnt != '0 && k < 20) begin @(negedge clk); k++; end
        wait_gnt(g, 20); chk("t4_gnt0", g, 4'b0001);
        drain(40);

        // Reset during the 4th word of requester 0
        s = cnt[0];
        offer(0, 6, 1); push(0, 6);
        wait_cnt(0, s + 3, 40);
        offer(1, 2, 1); push(1, 2);
        rst = 1'b1;
        #1;
        chk("t5_async_gnt", gnt, 0);
        chk("t5_async_wr", fifo_wr, 0);
        chk("t5_async_busy", busy, 0);
        @(posedge clk); #2; rst = 1'b0;
        wait_gnt(g, 20); chk("t5_restart_gnt", g, 4'b0001);
        drain(60);

        // Stall on a full FIFO
        @(posedge clk); #2;
        fifo_full = 1'b1;
        offer(1, 1, 1); push(1, 1);
        wait_gnt(g, 20); chk("t6_gnt", g, 4'b0010);
        held = 1; werr = 0; run = 1;
`ifdef ARB_WATCHDOG_EN
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (run && gnt == 4'b0010) held++; else run = 0;
            if (wdog_err) werr++;
        end
        chk("t6_wdog_held", held, 16);
        chk("t6_wdog_pulse", werr, 1);
`else
        for (int c = 0; c < 110; c++) begin
            @(negedge clk);
            if (run && gnt == 4'b0010) held++; else run = 0;
            if (wdog_err) werr++;
        end
        chk("t6_held", held, 111);
        chk("t6_wdog_quiet", werr, 0);
`endif
        @(posedge clk); #2; fifo_full = 1'b0;
        drain(40);

        chk("final_queue", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
